// File: rtl/player_gravity_controller.sv
// player_gravity_controller: fixed-point soul motion controller with four-way gravity,
// free mode and a FREE/GROUNDED/RISING/FALLING jump state machine.
module player_gravity_controller #(
    parameter int FRAC_BITS  = 4,
    parameter int START_X    = 320,
    parameter int START_Y    = 240,
    parameter int PLAYER_W   = 30,
    parameter int PLAYER_H   = 30,
    parameter int MOVE_SPEED = 18,
    parameter int JUMP_SPEED = 24,
    parameter int GRAVITY    = 12,
    parameter int MAX_FALL   = 560,
    parameter int JUMP_H     = 80
) (
    input  logic       clk_player_control,
    input  logic       reset,
    input  logic       switch_up,
    input  logic       switch_down,
    input  logic       switch_left,
    input  logic       switch_right,
    input  logic [9:0] game_display_x0,
    input  logic [9:0] game_display_y0,
    input  logic [9:0] game_display_x1,
    input  logic [9:0] game_display_y1,
    input  logic [2:0] gravity_direction,
    input  logic       is_collider_ground_player,
    input  logic [9:0] collider_ground_h_player,
    output logic [9:0] player_pos_x,
    output logic [9:0] player_pos_y,
    output logic [9:0] player_w,
    output logic [9:0] player_h,
    output logic       on_ground,
    output logic [1:0] player_state
);
    localparam int P = 10 + FRAC_BITS;
    localparam int S = P + 2;
    localparam logic signed [S-1:0] WU = S'(PLAYER_W << FRAC_BITS);
    localparam logic signed [S-1:0] HU = S'(PLAYER_H << FRAC_BITS);
    localparam logic signed [S-1:0] MS = S'(MOVE_SPEED);
    localparam logic signed [S-1:0] JS = S'(JUMP_SPEED);
    localparam logic signed [S-1:0] JH = S'(JUMP_H << FRAC_BITS);
    localparam logic signed [S-1:0] ZS = '0;
    localparam logic [S-1:0] GR = S'(GRAVITY);
    localparam logic [S-1:0] MF = S'(MAX_FALL);

    typedef enum logic [1:0] {FREE, GROUNDED, RISING, FALLING} state_t;

    state_t state_q, state_d;
    logic [P-1:0] pos_x_q, pos_y_q, pos_x_d, pos_y_d;
    logic [S-1:0] fall_speed_q, fall_speed_d, speed_sum;
    logic signed [S-1:0] apex_q, apex_d;
    logic [2:0] grav_q, grav;
    logic vert, far_floor, jump, lat_p, lat_n;
    logic signed [S-1:0] xs, ys, lo_x, hi_x, lo_y, hi_y, size, flr, wall;
    logic signed [S-1:0] a, b, a_n, b_n, rise, fall, lim, mx, my;

    function automatic logic signed [S-1:0] units(input logic [9:0] v);
        return $signed({{(S-10){1'b0}}, v}) <<< FRAC_BITS;
    endfunction

    // a = coordinate on the gravity axis, b = lateral coordinate; far_floor means floor at the high end
    always_comb begin
        grav         = gravity_direction > 3'd4 ? 3'd0 : gravity_direction;
        vert         = grav == 3'd1 || grav == 3'd3;
        far_floor    = grav == 3'd2 || grav == 3'd3;
        jump         = grav == 3'd1 ? switch_down : grav == 3'd2 ? switch_left :
                       grav == 3'd3 ? switch_up : switch_right;
        lat_p        = vert ? switch_right : switch_down;
        lat_n        = vert ? switch_left : switch_up;
        xs           = $signed({2'b00, pos_x_q});
        ys           = $signed({2'b00, pos_y_q});
        lo_x         = units(game_display_x0);
        hi_x         = units(game_display_x1) - WU;
        lo_y         = units(game_display_y0);
        hi_y         = units(game_display_y1) - HU;
        size         = vert ? HU : WU;
        a            = vert ? ys : xs;
        b            = vert ? xs : ys;
        flr          = is_collider_ground_player ? units(collider_ground_h_player) - (far_floor ? size : ZS) :
                       far_floor ? (vert ? hi_y : hi_x) : (vert ? lo_y : lo_x);
        wall         = far_floor ? (vert ? lo_y : lo_x) : (vert ? hi_y : hi_x);
        rise         = far_floor ? a - JS : a + JS;
        fall         = far_floor ? a + $signed(fall_speed_q >> FRAC_BITS) : a - $signed(fall_speed_q >> FRAC_BITS);
        lim          = far_floor ? (apex_q > wall ? apex_q : wall) : (apex_q < wall ? apex_q : wall);
        speed_sum    = fall_speed_q + GR;
        b_n          = b + (lat_p ? MS : ZS) - (lat_n ? MS : ZS);
        a_n          = a;
        state_d      = state_q;
        fall_speed_d = fall_speed_q;
        apex_d       = apex_q;
        mx           = xs;
        my           = ys;
        if (grav != grav_q) begin
            state_d      = grav == 3'd0 ? FREE : FALLING;
            fall_speed_d = '0;
            apex_d       = ZS;
        end else if (state_q == FREE) begin
            mx = xs + (switch_right ? MS : ZS) - (switch_left ? MS : ZS);
            my = ys + (switch_down ? MS : ZS) - (switch_up ? MS : ZS);
        end else begin
            if (state_q == GROUNDED) begin
                if (a != flr) begin
                    state_d      = FALLING;
                    fall_speed_d = '0;
                end else if (jump) begin
                    state_d = RISING;
                    apex_d  = far_floor ? a - JH : a + JH;
                end
            end else if (state_q == RISING) begin
                if (!jump || (far_floor ? rise <= lim : rise >= lim)) begin
                    a_n          = jump ? lim : a;
                    state_d      = FALLING;
                    fall_speed_d = '0;
                end else begin
                    a_n = rise;
                end
            end else begin
                fall_speed_d = speed_sum > MF ? MF : speed_sum;
                if (far_floor ? fall >= flr : fall <= flr) begin
                    a_n          = flr;
                    fall_speed_d = '0;
                    state_d      = GROUNDED;
                end else begin
                    a_n = fall;
                end
            end
            mx = vert ? b_n : a_n;
            my = vert ? a_n : b_n;
        end
        pos_x_d = P'(mx < lo_x ? lo_x : mx > hi_x ? hi_x : mx);
        pos_y_d = P'(my < lo_y ? lo_y : my > hi_y ? hi_y : my);
    end

    always_ff @(posedge clk_player_control) begin
        if (reset) begin
            state_q      <= FREE;
            pos_x_q      <= P'(START_X << FRAC_BITS);
            pos_y_q      <= P'(START_Y << FRAC_BITS);
            fall_speed_q <= '0;
            apex_q       <= ZS;
            grav_q       <= '0;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            fall_speed_q <= fall_speed_d;
            apex_q       <= apex_d;
            grav_q       <= grav;
        end
    end

    assign player_pos_x = pos_x_q[P-1:FRAC_BITS];
    assign player_pos_y = pos_y_q[P-1:FRAC_BITS];
    assign player_w     = 10'(PLAYER_W);
    assign player_h     = 10'(PLAYER_H);
    assign on_ground    = state_q == GROUNDED;
    assign player_state = state_q;
endmodule

// File: tb/tb_player_gravity_controller.sv
// tb_player_gravity_controller: directed scenarios plus randomized ticks against a behavioural motion model.
module tb_player_gravity_controller;
    logic       clk_player_control = 0;
    logic       reset = 1;
    logic       switch_up = 0, switch_down = 0, switch_left = 0, switch_right = 0;
    logic [9:0] game_display_x0 = 0, game_display_y0 = 0, game_display_x1 = 639, game_display_y1 = 479;
    logic [2:0] gravity_direction = 0;
    logic       is_collider_ground_player = 0;
    logic [9:0] collider_ground_h_player = 300;
    logic [9:0] player_pos_x, player_pos_y, player_w, player_h;
    logic       on_ground;
    logic [1:0] player_state;
    int checks = 0, fails = 0;
    int mx, my, mst, mfs, mapex, mg;

    player_gravity_controller dut (
        .clk_player_control(clk_player_control), .reset(reset),
        .switch_up(switch_up), .switch_down(switch_down), .switch_left(switch_left), .switch_right(switch_right),
        .game_display_x0(game_display_x0), .game_display_y0(game_display_y0),
        .game_display_x1(game_display_x1), .game_display_y1(game_display_y1),
        .gravity_direction(gravity_direction), .is_collider_ground_player(is_collider_ground_player),
        .collider_ground_h_player(collider_ground_h_player),
        .player_pos_x(player_pos_x), .player_pos_y(player_pos_y), .player_w(player_w), .player_h(player_h),
        .on_ground(on_ground), .player_state(player_state)
    );

    always #5 clk_player_control = ~clk_player_control;

    // Reference: positions in 1/16 pixel, states 0 FREE, 1 GROUNDED, 2 RISING, 3 FALLING
    task automatic model_update();
        int g, sgn, a, l, fl, wl, nxt, lim, jk, h, x0, x1, y0, y1;
        bit vert;
        if (reset) begin
            mx = 320 * 16; my = 240 * 16; mst = 0; mfs = 0; mapex = 0; mg = 0;
            return;
        end
        x0 = int'(game_display_x0); x1 = int'(game_display_x1);
        y0 = int'(game_display_y0); y1 = int'(game_display_y1);
        h = int'(collider_ground_h_player);
        g = gravity_direction > 4 ? 0 : int'(gravity_direction);
        vert = g == 1 || g == 3;
        sgn = (g == 2 || g == 3) ? 1 : -1;
        case (g)
            1: begin fl = is_collider_ground_player ? h : y0;      wl = y1 - 30; jk = int'(switch_down);  end
            2: begin fl = is_collider_ground_player ? h - 30 : x1 - 30; wl = x0; jk = int'(switch_left);  end
            3: begin fl = is_collider_ground_player ? h - 30 : y1 - 30; wl = y0; jk = int'(switch_up);    end
            4: begin fl = is_collider_ground_player ? h : x0;      wl = x1 - 30; jk = int'(switch_right); end
            default: begin fl = 0; wl = 0; jk = 0; end
        endcase
        fl *= 16; wl *= 16;
        a = vert ? my : mx;
        l = vert ? mx : my;
        if (g != mg) begin
            mst = g == 0 ? 0 : 3; mfs = 0; mapex = 0; mg = g;
        end else if (mst == 0) begin
            mx += 18 * (int'(switch_right) - int'(switch_left));
            my += 18 * (int'(switch_down) - int'(switch_up));
        end else begin
            l += vert ? 18 * (int'(switch_right) - int'(switch_left)) : 18 * (int'(switch_down) - int'(switch_up));
            if (mst == 1) begin
                if (a != fl) begin mst = 3; mfs = 0; end
                else if (jk != 0) begin mst = 2; mapex = a - sgn * 1280; end
            end else if (mst == 2) begin
                lim = (sgn * (mapex - wl) >= 0) ? mapex : wl;
                nxt = a - sgn * 24;
                if (jk == 0) begin mst = 3; mfs = 0; end
                else if (sgn * (nxt - lim) <= 0) begin a = lim; mst = 3; mfs = 0; end
                else a = nxt;
            end else begin
                nxt = a + sgn * (mfs / 16);
                mfs = (mfs + 12 > 560) ? 560 : mfs + 12;
                if (sgn * (nxt - fl) >= 0) begin a = fl; mfs = 0; mst = 1; end
                else a = nxt;
            end
            if (vert) begin my = a; mx = l; end
            else begin mx = a; my = l; end
        end
        if (mx < x0 * 16) mx = x0 * 16;
        if (mx > (x1 - 30) * 16) mx = (x1 - 30) * 16;
        if (my < y0 * 16) my = y0 * 16;
        if (my > (y1 - 30) * 16) my = (y1 - 30) * 16;
    endtask

    task automatic step();
        @(posedge clk_player_control);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; step(); step();
        checks++; if ({player_pos_x, player_pos_y} !== {10'd320, 10'd240}) begin fails++; $display("FAIL reset_pos: got %0d,%0d expected 320,240", player_pos_x, player_pos_y); end
        checks++; if ({player_state, on_ground} !== 3'b000) begin fails++; $display("FAIL reset_state: got %0d/%0b expected 0/0", player_state, on_ground); end
        checks++; if ({player_w, player_h} !== {10'd30, 10'd30}) begin fails++; $display("FAIL reset_size: got %0d,%0d expected 30,30", player_w, player_h); end
        reset = 0;
    endtask

    task automatic test_free_move();
        switch_right = 1; repeat (16) step();
        checks++; if ({player_pos_x, player_state} !== {10'd338, 2'd0}) begin fails++; $display("FAIL free_right: got x=%0d st=%0d expected 338/0", player_pos_x, player_state); end
        switch_left = 1; repeat (4) step();
        checks++; if (player_pos_x !== 10'd338) begin fails++; $display("FAIL free_cancel: got %0d expected 338", player_pos_x); end
        switch_left = 0; switch_right = 0; switch_up = 1; step(); switch_up = 0;
        checks++; if (player_pos_y !== 10'd238) begin fails++; $display("FAIL free_up: got %0d expected 238", player_pos_y); end
        switch_down = 1; step(); switch_down = 0;
        checks++; if (player_pos_y !== 10'd240) begin fails++; $display("FAIL free_down: got %0d expected 240", player_pos_y); end
    endtask

    task automatic test_fall_land();
        game_display_y0 = 200; game_display_y1 = 400; gravity_direction = 3; step();
        checks++; if (player_state !== 2'd3) begin fails++; $display("FAIL fall_start: got %0d expected 3", player_state); end
        for (int i = 0; i < 300 && player_state !== 2'd1; i++) step();
        checks++; if ({player_pos_y, player_state, on_ground} !== {10'd370, 2'd1, 1'b1}) begin fails++; $display("FAIL fall_land: got y=%0d st=%0d og=%0b expected 370/1/1", player_pos_y, player_state, on_ground); end
        step();
        checks++; if ({player_pos_y, player_state} !== {10'd370, 2'd1}) begin fails++; $display("FAIL stay_grounded: got y=%0d st=%0d expected 370/1", player_pos_y, player_state); end
    endtask

    task automatic test_jump_apex();
        switch_up = 1; step();
        checks++; if (player_state !== 2'd2) begin fails++; $display("FAIL jump_start: got %0d expected 2", player_state); end
        for (int i = 0; i < 200 && player_state !== 2'd3; i++) step();
        switch_up = 0;
        checks++; if ({player_pos_y, player_state} !== {10'd290, 2'd3}) begin fails++; $display("FAIL jump_apex: got y=%0d st=%0d expected 290/3", player_pos_y, player_state); end
        for (int i = 0; i < 300 && player_state !== 2'd1; i++) step();
        checks++; if ({player_pos_y, player_state} !== {10'd370, 2'd1}) begin fails++; $display("FAIL jump_land: got y=%0d st=%0d expected 370/1", player_pos_y, player_state); end
    endtask

    task automatic test_gravity_switch();
        switch_up = 1; repeat (5) step(); switch_up = 0; step();
        checks++; if (player_state !== 2'd3) begin fails++; $display("FAIL release_fall: got %0d expected 3", player_state); end
        gravity_direction = 2; step();
        checks++; if ({player_pos_x, player_state} !== {10'd338, 2'd3}) begin fails++; $display("FAIL grav_change: got x=%0d st=%0d expected 338/3", player_pos_x, player_state); end
        for (int i = 0; i < 300 && player_state !== 2'd1; i++) step();
        checks++; if ({player_pos_x, player_state} !== {10'd609, 2'd1}) begin fails++; $display("FAIL right_land: got x=%0d st=%0d expected 609/1", player_pos_x, player_state); end
        switch_left = 1; repeat (10) step(); switch_left = 0;
        checks++; if ({player_pos_x, player_state} !== {10'd595, 2'd2}) begin fails++; $display("FAIL left_jump: got x=%0d st=%0d expected 595/2", player_pos_x, player_state); end
    endtask

    task automatic test_collider();
        reset = 1; step(); reset = 0;
        gravity_direction = 3; is_collider_ground_player = 1; collider_ground_h_player = 300;
        for (int i = 0; i < 300 && player_state !== 2'd1; i++) step();
        checks++; if ({player_pos_y, player_state} !== {10'd270, 2'd1}) begin fails++; $display("FAIL collider_land: got y=%0d st=%0d expected 270/1", player_pos_y, player_state); end
        is_collider_ground_player = 0; step();
        checks++; if (player_state !== 2'd3) begin fails++; $display("FAIL collider_drop: got %0d expected 3", player_state); end
        for (int i = 0; i < 300 && player_state !== 2'd1; i++) step();
        checks++; if ({player_pos_y, player_state} !== {10'd370, 2'd1}) begin fails++; $display("FAIL floor_land: got y=%0d st=%0d expected 370/1", player_pos_y, player_state); end
    endtask

    task automatic test_reset_mid_rise();
        switch_up = 1; repeat (5) step();
        checks++; if (player_state !== 2'd2) begin fails++; $display("FAIL mid_rise: got %0d expected 2", player_state); end
        reset = 1; step(); reset = 0; switch_up = 0;
        checks++; if ({player_pos_x, player_pos_y, player_state} !== {10'd320, 10'd240, 2'd0}) begin fails++; $display("FAIL rise_reset: got %0d,%0d st=%0d expected 320,240/0", player_pos_x, player_pos_y, player_state); end
        step(); step();
        checks++; if ({player_pos_y, player_state} !== {10'd240, 2'd3}) begin fails++; $display("FAIL no_residual: got y=%0d st=%0d expected 240/3", player_pos_y, player_state); end
    endtask

    task automatic test_box_shrink();
        gravity_direction = 0; step();
        checks++; if (player_state !== 2'd0) begin fails++; $display("FAIL to_free: got %0d expected 0", player_state); end
        game_display_y1 = 250; game_display_x0 = 400; step();
        checks++; if ({player_pos_x, player_pos_y} !== {10'd400, 10'd220}) begin fails++; $display("FAIL box_shrink: got %0d,%0d expected 400,220", player_pos_x, player_pos_y); end
        game_display_x0 = 0; game_display_y0 = 0; game_display_x1 = 639; game_display_y1 = 479;
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) {switch_up, switch_down, switch_left, switch_right} = 4'($urandom);
            if ($urandom_range(0, 59) == 0) gravity_direction = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) begin
                is_collider_ground_player = ~is_collider_ground_player;
                collider_ground_h_player = 10'($urandom_range(130, 270));
            end
            if ($urandom_range(0, 149) == 0) begin
                game_display_x0 = 10'($urandom_range(0, 100)); game_display_x1 = 10'($urandom_range(400, 639));
                game_display_y0 = 10'($urandom_range(0, 100)); game_display_y1 = 10'($urandom_range(300, 479));
            end
            reset = $urandom_range(0, 299) == 0;
            step();
            checks++;
            if ({player_pos_x, player_pos_y, player_state, on_ground} !== {10'(mx / 16), 10'(my / 16), 2'(mst), mst == 1}) begin
                fails++;
                $display("FAIL random_tick %0d: got x=%0d y=%0d st=%0d og=%0b expected x=%0d y=%0d st=%0d", i, player_pos_x, player_pos_y, player_state, on_ground, mx / 16, my / 16, mst);
            end
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_free_move();
        test_fall_land();
        test_jump_apex();
        test_gravity_switch();
        test_collider();
        test_reset_mid_rise();
        test_box_shrink();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
